// File: rtl/simmem_wrsp_responder.sv
`default_nettype none
// ============================================================================
// Module  : simmem_wrsp_responder (with simmem_pkg)
// Brief   : Memory-end AXI write responder. It queues AW bursts, counts W beats
//           and returns one in-order B response per burst.
// Revision: 1.0 - initial release
// ============================================================================

package simmem_pkg;
    localparam int unsigned IDWidth          = 4;
    localparam int unsigned AddrWidth        = 16;
    localparam int unsigned DataWidth        = 32;
    localparam int unsigned BurstLenWidth    = 3;
    localparam int unsigned MaxBurstLenField = 2;
    localparam int unsigned RspPayloadWidth  = 2;

    typedef struct packed {
        logic [IDWidth-1:0]       id;
        logic [AddrWidth-1:0]     addr;
        logic [BurstLenWidth-1:0] burst_len;
    } waddr_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
    } wdata_t;

    typedef struct packed {
        logic [IDWidth-1:0]         id;
        logic [RspPayloadWidth-1:0] payload;
    } wrsp_merged_payload_t;

    typedef struct packed {
        wrsp_merged_payload_t merged_payload;
    } wrsp_t;

    // Burst length field encodes log2 of the beat count.
    function automatic logic [MaxBurstLenField:0] get_effective_burst_len(
        input logic [BurstLenWidth-1:0] burst_len
    );
        logic [MaxBurstLenField:0] w_one;
        w_one = 1;
        return w_one << burst_len;
    endfunction
endpackage

module simmem_wrsp_responder
    import simmem_pkg::*;
#(
    parameter int unsigned                AwQueueDepth = 4,
    parameter logic [RspPayloadWidth-1:0] RspOkay      = 2'd0,
    parameter logic [RspPayloadWidth-1:0] RspSlvErr    = 2'd2,
    parameter logic [RspPayloadWidth-1:0] RspDecErr    = 2'd3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  waddr_t                          waddr_i,
    input  logic                            waddr_in_valid_i,
    output logic                            waddr_in_ready_o,
    input  wdata_t                          wdata_i,
    input  logic                            wdata_in_valid_i,
    output logic                            wdata_in_ready_o,
    output wrsp_t                           wrsp_o,
    output logic                            wrsp_out_valid_o,
    input  logic                            wrsp_out_ready_i,
    output logic [$clog2(AwQueueDepth):0]   aw_count_o
);
    localparam int unsigned c_PTR_W  = $clog2(AwQueueDepth);
    localparam int unsigned c_CNT_W  = c_PTR_W + 1;
    localparam int unsigned c_BEAT_W = MaxBurstLenField + 1;
    localparam logic [c_CNT_W-1:0]       c_DEPTH   = c_CNT_W'(AwQueueDepth);
    localparam logic [BurstLenWidth-1:0] c_MAX_LEN = BurstLenWidth'(MaxBurstLenField);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    wrsp_t                 r_wrsp;

    logic [IDWidth-1:0]    r_q_id     [AwQueueDepth];
    logic [c_BEAT_W-1:0]   r_q_beats  [AwQueueDepth];
    logic                  r_q_decerr [AwQueueDepth];

    logic                  w_aw_push;
    logic                  w_beat_acc;
    logic                  w_final;
    logic                  w_rsp_hs;
    logic                  w_at_len;
    logic [c_BEAT_W-1:0]   w_cnt_inc;
    logic [BurstLenWidth-1:0] w_len_clamped;
    logic                  w_aw_decerr;
    logic [RspPayloadWidth-1:0] w_payload;
    logic                  w_unused_fields;

    assign waddr_in_ready_o = !rst_i && (r_count != c_DEPTH);
    assign wdata_in_ready_o = !rst_i && (r_state == ST_DATA);
    assign wrsp_out_valid_o = !rst_i && (r_state == ST_RSP);
    assign wrsp_o           = rst_i ? '0 : r_wrsp;
    assign aw_count_o       = rst_i ? '0 : r_count;

    assign w_aw_push  = waddr_in_valid_i && waddr_in_ready_o;
    assign w_beat_acc = wdata_in_valid_i && wdata_in_ready_o;
    assign w_rsp_hs   = wrsp_out_valid_o && wrsp_out_ready_i;

    assign w_aw_decerr   = (waddr_i.burst_len > c_MAX_LEN);
    assign w_len_clamped = w_aw_decerr ? c_MAX_LEN : waddr_i.burst_len;

    // A burst ends on an explicit last or when the declared count is reached.
    assign w_cnt_inc = r_beat_cnt + c_BEAT_W'(1);
    assign w_at_len  = (w_cnt_inc == r_q_beats[r_rd_ptr]);
    assign w_final   = w_beat_acc && (wdata_i.last || w_at_len);

    assign w_payload = r_q_decerr[r_rd_ptr]      ? RspDecErr :
                       (wdata_i.last == w_at_len) ? RspOkay   : RspSlvErr;

    // Address, data and strobes are accepted but never stored.
    assign w_unused_fields = ^{waddr_i.addr, wdata_i.data, wdata_i.strb};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_aw_push || (r_count != '0)) w_state_next = ST_DATA;
            ST_DATA: if (w_final) w_state_next = ST_RSP;
            ST_RSP: begin
                if (w_rsp_hs) begin
                    w_state_next = ((r_count != '0) || w_aw_push) ? ST_DATA : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_beat_cnt <= '0;
            r_wrsp     <= '0;
            for (int i = 0; i < AwQueueDepth; i++) begin
                r_q_id[i]     <= '0;
                r_q_beats[i]  <= '0;
                r_q_decerr[i] <= 1'b0;
            end
        end else begin
            r_state <= w_state_next;

            if (w_aw_push) begin
                r_q_id[r_wr_ptr]     <= waddr_i.id;
                r_q_beats[r_wr_ptr]  <= get_effective_burst_len(w_len_clamped);
                r_q_decerr[r_wr_ptr] <= w_aw_decerr;
                r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
            end

            if (w_final) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            case ({w_aw_push, w_final})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_beat_acc) begin
                if (w_final) begin
                    r_beat_cnt                    <= '0;
                    r_wrsp.merged_payload.id      <= r_q_id[r_rd_ptr];
                    r_wrsp.merged_payload.payload <= w_payload;
                end else begin
                    r_beat_cnt <= w_cnt_inc;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_simmem_wrsp_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_simmem_wrsp_responder
// Brief   : Self-checking bench: burst vector table plus corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_simmem_wrsp_responder;
    import simmem_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    waddr_t waddr;
    logic   aw_valid, aw_ready;
    wdata_t wdata;
    logic   w_valid, w_ready;
    wrsp_t  wrsp;
    logic   b_valid, b_ready;
    logic [2:0] aw_count;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] id;
        logic [1:0] payload;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] id;
        logic [2:0] len;
        int         nbeats;
        logic       last;
        logic [1:0] exp_payload;
    } vec_t;
    vec_t vecs[10];

    simmem_wrsp_responder dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .waddr_i          (waddr),
        .waddr_in_valid_i (aw_valid),
        .waddr_in_ready_o (aw_ready),
        .wdata_i          (wdata),
        .wdata_in_valid_i (w_valid),
        .wdata_in_ready_o (w_ready),
        .wrsp_o           (wrsp),
        .wrsp_out_valid_o (b_valid),
        .wrsp_out_ready_i (b_ready),
        .aw_count_o       (aw_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got no handshake within bound, expected one", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [2:0] len,
                           input logic [1:0] exp_payload, input bit track);
        int n = 0;
        waddr           = '0;
        waddr.id        = id;
        waddr.burst_len = len;
        waddr.addr      = 16'($urandom);
        aw_valid        = 1'b1;
        while (!aw_ready && n < 64) begin
            step();
            n++;
        end
        if (!aw_ready) begin
            timeout_fail("aw_handshake");
            aw_valid = 1'b0;
            return;
        end
        step();
        aw_valid = 1'b0;
        if (track) sb.push_back('{id, exp_payload});
    endtask

    task automatic send_w(input logic last);
        int n = 0;
        wdata.data = $urandom;
        wdata.strb = 4'hF;
        wdata.last = last;
        w_valid    = 1'b1;
        while (!w_ready && n < 64) begin
            step();
            n++;
        end
        if (!w_ready) begin
            timeout_fail("w_handshake");
            w_valid = 1'b0;
            return;
        end
        step();
        w_valid = 1'b0;
    endtask

    // Scoreboard: every B handshake must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && b_valid && b_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d, expected no response",
                         wrsp.merged_payload.id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(wrsp.merged_payload.id), 32'(e.id));
                chk("rsp_payload", 32'(wrsp.merged_payload.payload), 32'(e.payload));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // id, burst_len, beats sent, last on final beat, expected payload
        vecs[0] = '{4'd2,  3'd1, 2, 1'b1, 2'd0};
        vecs[1] = '{4'd1,  3'd2, 2, 1'b1, 2'd2};
        vecs[2] = '{4'd3,  3'd0, 1, 1'b0, 2'd2};
        vecs[3] = '{4'd0,  3'd5, 4, 1'b1, 2'd3};
        vecs[4] = '{4'd5,  3'd2, 4, 1'b1, 2'd0};
        vecs[5] = '{4'd7,  3'd2, 4, 1'b0, 2'd2};
        vecs[6] = '{4'd9,  3'd0, 1, 1'b1, 2'd0};
        vecs[7] = '{4'd15, 3'd7, 1, 1'b1, 2'd3};
        vecs[8] = '{4'd4,  3'd1, 1, 1'b1, 2'd2};
        vecs[9] = '{4'd6,  3'd3, 4, 1'b0, 2'd3};

        rst = 1'b1; aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b1;
        waddr = '0; wdata = '0;
        repeat (3) step();
        chk("rst_aw_ready", 32'(aw_ready), 0);
        chk("rst_w_ready",  32'(w_ready),  0);
        chk("rst_b_valid",  32'(b_valid),  0);
        chk("rst_count",    32'(aw_count), 0);
        rst = 1'b0;
        step();
        chk("idle_aw_ready", 32'(aw_ready), 1);
        chk("idle_w_ready",  32'(w_ready),  0);

        for (int i = 0; i < 10; i++) begin
            send_aw(vecs[i].id, vecs[i].len, vecs[i].exp_payload, 1'b1);
            for (int b = 0; b < vecs[i].nbeats; b++) begin
                send_w((b == vecs[i].nbeats - 1) ? vecs[i].last : 1'b0);
            end
            chk($sformatf("vec%0d_b_valid", i), 32'(b_valid), 1);
            step();
            chk($sformatf("vec%0d_count", i), 32'(aw_count), 0);
        end

        // Fill the AW queue, then free one slot while a fifth AW waits.
        for (int k = 0; k < 4; k++) send_aw(4'(k), 3'd0, 2'd0, 1'b1);
        chk("full_aw_ready", 32'(aw_ready), 0);
        chk("full_count",    32'(aw_count), 4);
        fork
            send_aw(4'd4, 3'd0, 2'd0, 1'b1);
            begin
                repeat (3) step();
                chk("stall_count", 32'(aw_count), 4);
                send_w(1'b1);
                chk("refill_aw_ready", 32'(aw_ready), 1);
            end
        join
        for (int k = 1; k < 5; k++) send_w(1'b1);
        repeat (3) step();
        chk("drain_count", 32'(aw_count), 0);

        // B backpressure: response must hold while ready is low.
        b_ready = 1'b0;
        send_aw(4'd6, 3'd1, 2'd0, 1'b1);
        send_aw(4'd7, 3'd0, 2'd2, 1'b1);
        send_w(1'b0);
        send_w(1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_b_valid", 32'(b_valid), 1);
            chk("bp_id",      32'(wrsp.merged_payload.id), 6);
            chk("bp_payload", 32'(wrsp.merged_payload.payload), 0);
            chk("bp_w_ready", 32'(w_ready), 0);
            step();
        end
        b_ready = 1'b1;
        step();
        chk("bp_data_next", 32'(w_ready), 1);
        chk("bp_b_dropped", 32'(b_valid), 0);
        send_w(1'b0);
        repeat (2) step();

        // Reset in the middle of a burst discards it silently.
        send_aw(4'd8, 3'd1, 2'd0, 1'b0);
        send_w(1'b0);
        rst = 1'b1;
        step();
        chk("mid_rst_b_valid",  32'(b_valid),  0);
        chk("mid_rst_w_ready",  32'(w_ready),  0);
        chk("mid_rst_aw_ready", 32'(aw_ready), 0);
        chk("mid_rst_count",    32'(aw_count), 0);
        chk("mid_rst_wrsp",     32'(wrsp),     0);
        rst = 1'b0;
        wdata.last = 1'b1;
        w_valid    = 1'b1;
        repeat (3) step();
        chk("post_rst_w_ready", 32'(w_ready),  0);
        chk("post_rst_count",   32'(aw_count), 0);
        w_valid = 1'b0;
        repeat (8) step();
        chk("post_rst_b_valid", 32'(b_valid), 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
